// File: rtl/cic_comp_fir.sv
// cic_comp_fir: 5-tap symmetric compensation FIR for the CIC decimator output.
// Each rising edge of d_clk loads one sample into the delay line. One shared
// multiply-accumulate unit then runs for 5 clk cycles. The rounded result is
// presented on d_out, and d_valid pulses for one clk cycle.
// Build option: define CIC_COMP_SAT_EN to clamp the result to the WIDTH range.
// Without it, the result wraps to WIDTH bits.
module cic_comp_fir #(
  parameter int WIDTH = 8,
  parameter int SHIFT = 9,
  parameter int ACC_W = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] d_in,
  input  logic                    d_clk,
  output logic signed [WIDTH-1:0] d_out,
  output logic                    d_valid,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Half an output LSB, added before the right shift so that rounding is half-up.
  localparam logic signed [ACC_W-1:0] RND_C = ACC_W'(32'sd1 <<< (SHIFT - 1));

  state_t                   state_r;
  state_t                   next_state_s;
  logic signed [WIDTH-1:0]  line_r [0:4];
  logic signed [ACC_W-1:0]  acc_r;
  logic [2:0]               k_r;
  logic                     d_clk_q_r;
  logic                     armed_r;
  logic                     ev_s;
  logic signed [WIDTH-1:0]  tap_s;
  logic signed [11:0]       coef_s;
  logic signed [WIDTH+11:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  r_s;
  logic signed [WIDTH-1:0]  d_out_r;
  logic                     d_valid_r;
  logic                     busy_r;
  logic                     overrun_r;

  // The kernel is symmetric. Its taps sum to 512, so it has unity DC gain after the shift.
  function automatic logic signed [11:0] coef(input logic [2:0] idx);
    case (idx)
      3'd0:    coef = 12'sd16;
      3'd1:    coef = -12'sd64;
      3'd2:    coef = 12'sd608;
      3'd3:    coef = -12'sd64;
      3'd4:    coef = 12'sd16;
      default: coef = 12'sd0;
    endcase
  endfunction

`ifdef CIC_COMP_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX_C = ACC_W'((32'sd1 <<< (WIDTH - 1)) - 32'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN_C = ACC_W'(-(32'sd1 <<< (WIDTH - 1)));

  // Clamp the rounded result to the signed WIDTH range.
  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX_C) begin
      narrow = SAT_MAX_C[WIDTH-1:0];
    end else if (v < SAT_MIN_C) begin
      narrow = SAT_MIN_C[WIDTH-1:0];
    end else begin
      narrow = v[WIDTH-1:0];
    end
  endfunction
`else
  // Keep the low WIDTH bits of the rounded result, so out-of-range values wrap around.
  function automatic logic signed [WIDTH-1:0] narrow(input logic signed [ACC_W-1:0] v);
    narrow = v[WIDTH-1:0];
  endfunction
`endif

  // Detect a rising edge of d_clk. armed_r suppresses a d_clk that was already high when reset was released.
  always_comb begin
    ev_s = d_clk & ~d_clk_q_r & armed_r;
  end

  // Select the current delay-line tap and coefficient, and form their sign-extended product.
  always_comb begin
    case (k_r)
      3'd0:    tap_s = line_r[0];
      3'd1:    tap_s = line_r[1];
      3'd2:    tap_s = line_r[2];
      3'd3:    tap_s = line_r[3];
      3'd4:    tap_s = line_r[4];
      default: tap_s = '0;
    endcase
    coef_s     = coef(k_r);
    prod_s     = tap_s * coef_s;
    prod_ext_s = ACC_W'(prod_s);
    r_s        = (acc_r + RND_C) >>> SHIFT;
  end

  // Next-state logic for the IDLE -> MAC (5 cycles) -> OUT sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ev_s) begin
          next_state_s = MAC;
        end else begin
          next_state_s = IDLE;
        end
      end
      MAC: begin
        if (k_r == 3'd4) begin
          next_state_s = OUT;
        end else begin
          next_state_s = MAC;
        end
      end
      OUT:     next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Datapath: sample capture, MAC accumulation, output register and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 5; j++) begin
        line_r[j] <= '0;
      end
      acc_r     <= '0;
      k_r       <= 3'd0;
      d_clk_q_r <= 1'b0;
      armed_r   <= 1'b0;
      d_out_r   <= '0;
      d_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      d_clk_q_r <= d_clk;
      armed_r   <= armed_r | ~d_clk;
      d_valid_r <= 1'b0;
      busy_r    <= (next_state_s != IDLE);
      if (ev_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (ev_s) begin
            for (int j = 4; j > 0; j--) begin
              line_r[j] <= line_r[j-1];
            end
            line_r[0] <= d_in;
            acc_r     <= '0;
            k_r       <= 3'd0;
          end
        end
        MAC: begin
          acc_r <= acc_r + prod_ext_s;
          k_r   <= k_r + 3'd1;
        end
        OUT: begin
          d_out_r   <= narrow(r_s);
          d_valid_r <= 1'b1;
        end
        default: begin
          acc_r <= '0;
        end
      endcase
    end
  end

  assign d_out   = d_out_r;
  assign d_valid = d_valid_r;
  assign busy    = busy_r;
  assign overrun = overrun_r;

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Decimated-rate compensation FIR that sits directly downstream of the CIC decimator.
- Consumes the CIC's signed `d_out` and its `d_clk` sample clock, and flattens the CIC sinc passband droop with a fixed 5-tap symmetric kernel.
- Uses a single time-shared multiplier-accumulator (MAC) running on the fast system clock.
- Produces one filtered sample per CIC output sample, plus a valid strobe.

Parameters:
- WIDTH, 8: input/output sample width (signed, two's complement).
- SHIFT, 9: output scaling right-shift; coefficient sum is 512, so DC gain = 1.
- ACC_W, 24: accumulator width; must be >= WIDTH+15.

Ports:
- clk  input  1  system clock, same domain as the CIC.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  WIDTH  signed sample from the CIC `d_out`.
- d_clk  input  1  CIC output sample clock; generated in the `clk` domain, no synchroniser needed.
- d_out  output  WIDTH  signed filtered sample.
- d_valid  output  1  one-`clk` pulse; `d_out` is new.
- busy  output  1  high while a sample is being filtered.
- overrun  output  1  sticky; a sample was dropped.

Behaviour:
- Coefficients, fixed, 12-bit signed: c0..c4 = 16, -64, 608, -64, 16.
- Delay line: line[0..4], signed WIDTH each; line[0] is the newest sample.
- Sample event:
  - d_clk_q is `d_clk` registered on `clk`.
  - event = d_clk & ~d_clk_q, i.e. the rising edge of `d_clk`.
- FSM states: IDLE, MAC, OUT.
- IDLE:
  - On event: line shifts (line[k] <= line[k-1], line[0] <= d_in), acc <= 0, k <= 0, go to MAC.
- MAC:
  - Each cycle: acc <= acc + sign-extended(line[k]*c[k]), k <= k+1.
  - After k=4, go to OUT. MAC therefore lasts exactly 5 cycles.
- OUT:
  - r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up).
  - `d_out` <= r narrowed to WIDTH (see Optional Feature), `d_valid` <= 1, go to IDLE.
- Latency:
  - `d_valid` is high for exactly one `clk`, in the 7th cycle after the cycle in which event was high.
  - `d_out` holds its value until the next OUT.
- `busy` = (state != IDLE).
- Event while `busy`:
  - The sample is dropped; line is not shifted.
  - `overrun` <= 1 and stays set until reset.
  - The filter in progress completes unaffected.
- Minimum event spacing without loss is 7 `clk`. The CIC `decimation_ratio` must be >= 8.
- Reset (asynchronous, any state, including mid-MAC):
  - state = IDLE; line, acc, k = 0.
  - d_out = 0, d_valid = 0, busy = 0, overrun = 0, d_clk_q = 0.
  - A partially accumulated result is discarded; no `d_valid` is issued for it.
- After reset release, a `d_clk` that is already high does not produce an event until it falls and rises again.

Optional Feature:
- Macro: CIC_COMP_SAT_EN.
- Defined: r is clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1], i.e. [-128, 127] at WIDTH=8.
- Undefined: `d_out` = r[WIDTH-1:0]; wrap-around, no clamp.
- The rest of the behaviour, including timing, is identical in both builds.

Test Plan:
- Impulse: after reset, d_in=64 for one `d_clk` sample, then 0s, event spacing 8 `clk` -> successive `d_out` = 2, -8, 76, -8, 2, then 0. Each `d_valid` lands 7 cycles after its event.
- DC: d_in held at 100 for 6+ samples -> from the 5th output onward `d_out` = 100. Hold -100 -> `d_out` = -100.
- Overflow, time sequence -128, -128, 127, -128, -128 -> r = 175 on the 5th output:
  - With CIC_COMP_SAT_EN: `d_out` = 127.
  - Without CIC_COMP_SAT_EN: `d_out` = -81.
- Overrun: two `d_clk` rises 3 `clk` apart -> exactly one `d_valid`, `overrun`=1 and it stays 1. A later, correctly spaced sample still filters normally.
- Reset mid-MAC: assert `rst` 2 cycles after an event -> `d_valid` is never pulsed for that sample; `d_out`=0, `busy`=0, line cleared. The next impulse reproduces the impulse-scenario response exactly.
- Cascade with the CIC (width 18, `decimation_ratio`=8, file-driven `d_in`): no `overrun`, one `d_valid` per `d_clk` rise.
